rf_exe0_reg: RTL and testbench
==============================

// Module: rf_exe0_reg
// PURPOSE
// - Dual-issue pipeline register between register-read (rf) and exe0.
// - Captures both lanes' uops and operands and resolves RAW hazards by late forwarding from exe1 and wb.
// - Keeps a stalled pair's operands fresh by snooping result buses while held.
// - Its rj/rk/en outputs feed the downstream hazard/stall logic; that logic's stall comes back as stall_in.
// PARAMETERS
// - DATA_W  32  operand/result width
// - UOP_W   32  uop bundle width; instantiate with the `UOP_TYPE width
// PORTS
// - clk             in   1       rising-edge clock
// - rstn            in   1       async active-low reset
// - stall_in        in   1       hold all contents (combined stall)
// - flush_in        in   1       kill both lanes (branch mispredict/exception)
// - eu{0,1}_en_in   in   1       lane valid from rf
// - eu{0,1}_uop_in  in   UOP_W   decoded uop
// - eu{0,1}_rj_in, eu{0,1}_rk_in, eu{0,1}_rd_in  in  5  register indices
// - eu{0,1}_rj_data, eu{0,1}_rk_data  in  DATA_W  regfile read data
// - ex1_{0,1}_we, ex1_{0,1}_rd, ex1_{0,1}_data  in  1/5/DATA_W  exe1 result buses
// - wb_{0,1}_we, wb_{0,1}_rd, wb_{0,1}_data      in  1/5/DATA_W  writeback buses
// - eu{0,1}_en_out   out  1       lane valid into exe0
// - eu{0,1}_uop_out  out  UOP_W   registered uop
// - eu{0,1}_rj_out, eu{0,1}_rk_out, eu{0,1}_rd_out  out  5  registered indices
// - eu{0,1}_src1, eu{0,1}_src2  out  DATA_W  resolved rj/rk operands
// BEHAVIOUR
// - Reset (rstn=0, async): every output and internal register is 0; lanes invalid.
// - Latency: 1 cycle rf->exe0 when stall_in=0.
// - Priority per edge: flush_in > stall_in > capture.
// - flush_in=1: both en_out <= 0; other fields don't-care, hold. This also applies when stall_in=1.
// - stall_in=1, flush_in=0:
//   - en/uop/indices hold.
//   - src1/src2 are re-resolved every cycle, using the held value as the default source (snoop).
// - Capture (stall=0, flush=0):
//   - All fields load from rf.
//   - src resolved with regfile data as the default source.
//   - en_out <= en_in.
// - Forward select per operand with index r; first match wins:
//   1. ex1_1
//   2. ex1_0
//   3. wb_1
//   4. wb_0
//   5. default (regfile data or held value)
//   - A source matches iff we=1 && rd==r && r!=0.
//   - Lane 1 beats lane 0 because lane 1 is younger in program order.
// - r==0: operand is forced to 0 regardless of buses or regfile data.
// - Same-cycle regfile write/read collision: resolved by the wb match; no dependence on regfile write-through.
// - Intra-pair RAW (eu1 reads eu0 rd) is never issued as a pair by issue logic. This block does not check it.
// - Invalid lane (en=0): its operands still update. They are don't-care and must not produce X on outputs after reset.
// - Reset mid-stall: all state clears; the next capture after rstn rises behaves as the first.
// STRUCTURE
// - Shared package/header: DATA_W and REG_IDX_W=5 constants; forward-source encoding (FWD_EX1_1..FWD_DEF) for debug/coverage.
// - Sub-module fwd_sel (combinational): inputs are r, default data and the four buses; output is the resolved data.
//   - Instantiated 4x: 2 lanes x rj/rk.
//   - Default mux (regfile vs held) selected by stall_in outside fwd_sel.
// - Sequential part: one always block per lane, async reset on negedge rstn.
// TESTING
// - Capture:
//   - Stimulus: eu0 rj=3 (rf 0x11), rk=0 (rf 0xFF); no buses.
//   - Next cycle: en_out=1, src1=0x11, src2=0.
// - Forward priority:
//   - Stimulus: rj=5; ex1_0 we rd5=0xA; wb_1 we rd5=0xB; rf=0xC.
//   - Result: src1=0xA.
//   - Adding ex1_1 rd5=0xD gives src1=0xD.
// - Stall snoop:
//   - Stimulus: capture eu1 rk=7 with rf=0x1; hold stall 3 cycles; wb_0 rd7=0x55 in stall cycle 2.
//   - Result: src2=0x55 after that edge; uop/indices unchanged; stays 0x55 after stall drops until next capture.
// - Flush vs stall:
//   - Stimulus: stall_in=1 and flush_in=1 same cycle with both lanes valid.
//   - Result: both en_out=0 next edge.
// - r0 guard:
//   - Stimulus: rj=0 with ex1_1 we rd0=0xDEAD.
//   - Result: src1=0.
// - Async reset:
//   - Stimulus: assert rstn=0 mid-cycle during stall.
//   - Result: outputs 0 immediately, without waiting for clk.
//   - Release, capture rj=2 rf=0x4: src1=0x4.

Source files
------------

// File: rtl/rf_exe0_reg_pkg.sv
// Shared constants and types for the rf->exe0 dual-issue pipeline register.
// The forward-source encoding names each bypass point in priority order.
package rf_exe0_reg_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam int UOP_W     = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    FWD_EX1_1 = 3'd0,
    FWD_EX1_0 = 3'd1,
    FWD_WB_1  = 3'd2,
    FWD_WB_0  = 3'd3,
    FWD_DEF   = 3'd4
  } fwd_src_e;

  // r0 is hardwired zero, so a write that names it is never a producer.
  function automatic logic fwd_hit(input logic we, input reg_idx_t rd, input reg_idx_t r);
    return we && (rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/rf_exe0_reg_if.sv
// Bundle between rf stage, result buses and exe0 for the rf_exe0_reg pipeline register.
// master drives rf/bus inputs and observes exe0 outputs; slave is the register itself.
interface rf_exe0_reg_if #(
  parameter int DATA_W = rf_exe0_reg_pkg::DATA_W,
  parameter int UOP_W  = rf_exe0_reg_pkg::UOP_W
);
  import rf_exe0_reg_pkg::*;

  logic              stall_in;
  logic              flush_in;

  logic              eu0_en_in,   eu1_en_in;
  logic [UOP_W-1:0]  eu0_uop_in,  eu1_uop_in;
  reg_idx_t          eu0_rj_in,   eu1_rj_in;
  reg_idx_t          eu0_rk_in,   eu1_rk_in;
  reg_idx_t          eu0_rd_in,   eu1_rd_in;
  logic [DATA_W-1:0] eu0_rj_data, eu1_rj_data;
  logic [DATA_W-1:0] eu0_rk_data, eu1_rk_data;

  logic              ex1_0_we,   ex1_1_we,   wb_0_we,   wb_1_we;
  reg_idx_t          ex1_0_rd,   ex1_1_rd,   wb_0_rd,   wb_1_rd;
  logic [DATA_W-1:0] ex1_0_data, ex1_1_data, wb_0_data, wb_1_data;

  logic              eu0_en_out,  eu1_en_out;
  logic [UOP_W-1:0]  eu0_uop_out, eu1_uop_out;
  reg_idx_t          eu0_rj_out,  eu1_rj_out;
  reg_idx_t          eu0_rk_out,  eu1_rk_out;
  reg_idx_t          eu0_rd_out,  eu1_rd_out;
  logic [DATA_W-1:0] eu0_src1,    eu1_src1;
  logic [DATA_W-1:0] eu0_src2,    eu1_src2;

  modport master (
    output stall_in, flush_in,
    output eu0_en_in, eu1_en_in, eu0_uop_in, eu1_uop_in,
    output eu0_rj_in, eu1_rj_in, eu0_rk_in, eu1_rk_in, eu0_rd_in, eu1_rd_in,
    output eu0_rj_data, eu1_rj_data, eu0_rk_data, eu1_rk_data,
    output ex1_0_we, ex1_1_we, wb_0_we, wb_1_we,
    output ex1_0_rd, ex1_1_rd, wb_0_rd, wb_1_rd,
    output ex1_0_data, ex1_1_data, wb_0_data, wb_1_data,
    input  eu0_en_out, eu1_en_out, eu0_uop_out, eu1_uop_out,
    input  eu0_rj_out, eu1_rj_out, eu0_rk_out, eu1_rk_out, eu0_rd_out, eu1_rd_out,
    input  eu0_src1, eu1_src1, eu0_src2, eu1_src2
  );

  modport slave (
    input  stall_in, flush_in,
    input  eu0_en_in, eu1_en_in, eu0_uop_in, eu1_uop_in,
    input  eu0_rj_in, eu1_rj_in, eu0_rk_in, eu1_rk_in, eu0_rd_in, eu1_rd_in,
    input  eu0_rj_data, eu1_rj_data, eu0_rk_data, eu1_rk_data,
    input  ex1_0_we, ex1_1_we, wb_0_we, wb_1_we,
    input  ex1_0_rd, ex1_1_rd, wb_0_rd, wb_1_rd,
    input  ex1_0_data, ex1_1_data, wb_0_data, wb_1_data,
    output eu0_en_out, eu1_en_out, eu0_uop_out, eu1_uop_out,
    output eu0_rj_out, eu1_rj_out, eu0_rk_out, eu1_rk_out, eu0_rd_out, eu1_rd_out,
    output eu0_src1, eu1_src1, eu0_src2, eu1_src2
  );

endinterface

// File: rtl/rf_exe0_reg_fwd_sel.sv
// Combinational operand resolver: picks the youngest matching result bus, else the default.
// Index 0 always resolves to zero.
module rf_exe0_reg_fwd_sel #(
  parameter int DATA_W = rf_exe0_reg_pkg::DATA_W
) (
  input  rf_exe0_reg_pkg::reg_idx_t r_i,
  input  logic [DATA_W-1:0]         def_i,
  input  logic                      ex1_0_we_i,
  input  rf_exe0_reg_pkg::reg_idx_t ex1_0_rd_i,
  input  logic [DATA_W-1:0]         ex1_0_data_i,
  input  logic                      ex1_1_we_i,
  input  rf_exe0_reg_pkg::reg_idx_t ex1_1_rd_i,
  input  logic [DATA_W-1:0]         ex1_1_data_i,
  input  logic                      wb_0_we_i,
  input  rf_exe0_reg_pkg::reg_idx_t wb_0_rd_i,
  input  logic [DATA_W-1:0]         wb_0_data_i,
  input  logic                      wb_1_we_i,
  input  rf_exe0_reg_pkg::reg_idx_t wb_1_rd_i,
  input  logic [DATA_W-1:0]         wb_1_data_i,
  output logic [DATA_W-1:0]         data_o
);
  import rf_exe0_reg_pkg::*;

  fwd_src_e sel;

  // Nearer stage first, and within a stage lane 1 is younger than lane 0.
  always_comb begin
    sel = FWD_DEF;
    if (fwd_hit(ex1_1_we_i, ex1_1_rd_i, r_i))      sel = FWD_EX1_1;
    else if (fwd_hit(ex1_0_we_i, ex1_0_rd_i, r_i)) sel = FWD_EX1_0;
    else if (fwd_hit(wb_1_we_i, wb_1_rd_i, r_i))   sel = FWD_WB_1;
    else if (fwd_hit(wb_0_we_i, wb_0_rd_i, r_i))   sel = FWD_WB_0;
  end

  always_comb begin
    data_o = '0;
    case (sel)
      FWD_EX1_1: data_o = ex1_1_data_i;
      FWD_EX1_0: data_o = ex1_0_data_i;
      FWD_WB_1:  data_o = wb_1_data_i;
      FWD_WB_0:  data_o = wb_0_data_i;
      default:   data_o = (r_i == '0) ? '0 : def_i;
    endcase
  end

endmodule

// File: rtl/rf_exe0_reg.sv
// Dual-issue rf->exe0 pipeline register with late forwarding, 1-cycle latency.
// stall_in holds the pair while operands keep snooping result buses; flush_in kills both lanes.
module rf_exe0_reg #(
  parameter int DATA_W = rf_exe0_reg_pkg::DATA_W,
  parameter int UOP_W  = rf_exe0_reg_pkg::UOP_W
) (
  input logic          clk,
  input logic          rstn,
  rf_exe0_reg_if.slave bus
);
  import rf_exe0_reg_pkg::*;

  logic [1:0]                  en_in;
  logic [1:0][UOP_W-1:0]       uop_in;
  logic [1:0][REG_IDX_W-1:0]   rj_in, rk_in, rd_in;
  logic [1:0][DATA_W-1:0]      rj_data, rk_data;

  assign en_in   = {bus.eu1_en_in,   bus.eu0_en_in};
  assign uop_in  = {bus.eu1_uop_in,  bus.eu0_uop_in};
  assign rj_in   = {bus.eu1_rj_in,   bus.eu0_rj_in};
  assign rk_in   = {bus.eu1_rk_in,   bus.eu0_rk_in};
  assign rd_in   = {bus.eu1_rd_in,   bus.eu0_rd_in};
  assign rj_data = {bus.eu1_rj_data, bus.eu0_rj_data};
  assign rk_data = {bus.eu1_rk_data, bus.eu0_rk_data};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic              en_q;
    logic [UOP_W-1:0]  uop_q;
    reg_idx_t          rj_q, rk_q, rd_q;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [DATA_W-1:0] src1_d, src2_d;
    reg_idx_t          rj_sel, rk_sel;
    logic [DATA_W-1:0] rj_def, rk_def;

    // While held, the pair re-resolves its own indices against its own operands.
    assign rj_sel = bus.stall_in ? rj_q   : rj_in[l];
    assign rk_sel = bus.stall_in ? rk_q   : rk_in[l];
    assign rj_def = bus.stall_in ? src1_q : rj_data[l];
    assign rk_def = bus.stall_in ? src2_q : rk_data[l];

    rf_exe0_reg_fwd_sel #(.DATA_W(DATA_W)) u_fwd_rj (
      .r_i(rj_sel), .def_i(rj_def),
      .ex1_0_we_i(bus.ex1_0_we), .ex1_0_rd_i(bus.ex1_0_rd), .ex1_0_data_i(bus.ex1_0_data),
      .ex1_1_we_i(bus.ex1_1_we), .ex1_1_rd_i(bus.ex1_1_rd), .ex1_1_data_i(bus.ex1_1_data),
      .wb_0_we_i(bus.wb_0_we),   .wb_0_rd_i(bus.wb_0_rd),   .wb_0_data_i(bus.wb_0_data),
      .wb_1_we_i(bus.wb_1_we),   .wb_1_rd_i(bus.wb_1_rd),   .wb_1_data_i(bus.wb_1_data),
      .data_o(src1_d)
    );

    rf_exe0_reg_fwd_sel #(.DATA_W(DATA_W)) u_fwd_rk (
      .r_i(rk_sel), .def_i(rk_def),
      .ex1_0_we_i(bus.ex1_0_we), .ex1_0_rd_i(bus.ex1_0_rd), .ex1_0_data_i(bus.ex1_0_data),
      .ex1_1_we_i(bus.ex1_1_we), .ex1_1_rd_i(bus.ex1_1_rd), .ex1_1_data_i(bus.ex1_1_data),
      .wb_0_we_i(bus.wb_0_we),   .wb_0_rd_i(bus.wb_0_rd),   .wb_0_data_i(bus.wb_0_data),
      .wb_1_we_i(bus.wb_1_we),   .wb_1_rd_i(bus.wb_1_rd),   .wb_1_data_i(bus.wb_1_data),
      .data_o(src2_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        en_q   <= 1'b0;
        uop_q  <= '0;
        rj_q   <= '0;
        rk_q   <= '0;
        rd_q   <= '0;
        src1_q <= '0;
        src2_q <= '0;
      end else if (bus.flush_in) begin
        en_q   <= 1'b0;
      end else if (bus.stall_in) begin
        src1_q <= src1_d;
        src2_q <= src2_d;
      end else begin
        en_q   <= en_in[l];
        uop_q  <= uop_in[l];
        rj_q   <= rj_in[l];
        rk_q   <= rk_in[l];
        rd_q   <= rd_in[l];
        src1_q <= src1_d;
        src2_q <= src2_d;
      end
    end
  end

  assign bus.eu0_en_out  = g_lane[0].en_q;
  assign bus.eu0_uop_out = g_lane[0].uop_q;
  assign bus.eu0_rj_out  = g_lane[0].rj_q;
  assign bus.eu0_rk_out  = g_lane[0].rk_q;
  assign bus.eu0_rd_out  = g_lane[0].rd_q;
  assign bus.eu0_src1    = g_lane[0].src1_q;
  assign bus.eu0_src2    = g_lane[0].src2_q;

  assign bus.eu1_en_out  = g_lane[1].en_q;
  assign bus.eu1_uop_out = g_lane[1].uop_q;
  assign bus.eu1_rj_out  = g_lane[1].rj_q;
  assign bus.eu1_rk_out  = g_lane[1].rk_q;
  assign bus.eu1_rd_out  = g_lane[1].rd_q;
  assign bus.eu1_src1    = g_lane[1].src1_q;
  assign bus.eu1_src2    = g_lane[1].src2_q;

endmodule

// File: tb/tb_rf_exe0_reg.sv
// Directed bench for rf_exe0_reg: capture, forward priority, stall snoop, flush, r0 and async reset.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_rf_exe0_reg;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rf_exe0_reg_if #(.DATA_W(32), .UOP_W(32)) bus ();

  rf_exe0_reg #(.DATA_W(32), .UOP_W(32)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  task automatic clear_inputs();
    bus.stall_in = 0; bus.flush_in = 0;
    bus.eu0_en_in = 0; bus.eu0_uop_in = 0; bus.eu0_rj_in = 0; bus.eu0_rk_in = 0; bus.eu0_rd_in = 0;
    bus.eu0_rj_data = 0; bus.eu0_rk_data = 0;
    bus.eu1_en_in = 0; bus.eu1_uop_in = 0; bus.eu1_rj_in = 0; bus.eu1_rk_in = 0; bus.eu1_rd_in = 0;
    bus.eu1_rj_data = 0; bus.eu1_rk_data = 0;
    bus.ex1_0_we = 0; bus.ex1_0_rd = 0; bus.ex1_0_data = 0;
    bus.ex1_1_we = 0; bus.ex1_1_rd = 0; bus.ex1_1_data = 0;
    bus.wb_0_we = 0;  bus.wb_0_rd = 0;  bus.wb_0_data = 0;
    bus.wb_1_we = 0;  bus.wb_1_rd = 0;  bus.wb_1_data = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    #1;
    chk("reset_en0",   {31'b0, bus.eu0_en_out}, 32'h0);
    chk("reset_en1",   {31'b0, bus.eu1_en_out}, 32'h0);
    chk("reset_src",   bus.eu0_src1 | bus.eu0_src2 | bus.eu1_src1 | bus.eu1_src2, 32'h0);
    chk("reset_uop",   bus.eu0_uop_out | bus.eu1_uop_out, 32'h0);
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_capture();
    @(negedge clk);
    clear_inputs();
    bus.eu0_en_in = 1; bus.eu0_uop_in = 32'h1234; bus.eu0_rd_in = 9;
    bus.eu0_rj_in = 3; bus.eu0_rj_data = 32'h11;
    bus.eu0_rk_in = 0; bus.eu0_rk_data = 32'hFF;
    @(negedge clk);
    chk("cap_en0",  {31'b0, bus.eu0_en_out}, 32'h1);
    chk("cap_en1",  {31'b0, bus.eu1_en_out}, 32'h0);
    chk("cap_src1", bus.eu0_src1, 32'h11);
    chk("cap_src2_r0", bus.eu0_src2, 32'h0);
    chk("cap_uop",  bus.eu0_uop_out, 32'h1234);
    chk("cap_rd",   {27'b0, bus.eu0_rd_out}, 32'd9);
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    bus.eu0_en_in = 1; bus.eu0_rj_in = 5; bus.eu0_rj_data = 32'hC;
    bus.ex1_0_we = 1; bus.ex1_0_rd = 5; bus.ex1_0_data = 32'hA;
    bus.wb_1_we = 1;  bus.wb_1_rd = 5;  bus.wb_1_data = 32'hB;
    @(negedge clk);
    chk("fwd_ex1_0_over_wb1", bus.eu0_src1, 32'hA);
    bus.ex1_1_we = 1; bus.ex1_1_rd = 5; bus.ex1_1_data = 32'hD;
    @(negedge clk);
    chk("fwd_ex1_1_first", bus.eu0_src1, 32'hD);
    bus.ex1_1_we = 0; bus.ex1_0_we = 0;
    bus.wb_0_we = 1; bus.wb_0_rd = 5; bus.wb_0_data = 32'hE;
    @(negedge clk);
    chk("fwd_wb1_over_wb0", bus.eu0_src1, 32'hB);
    bus.wb_1_we = 0;
    bus.eu1_en_in = 1; bus.eu1_rk_in = 5; bus.eu1_rk_data = 32'h3;
    @(negedge clk);
    chk("fwd_wb0_lane0", bus.eu0_src1, 32'hE);
    chk("fwd_wb0_lane1_rk", bus.eu1_src2, 32'hE);
    bus.wb_0_rd = 6;
    @(negedge clk);
    chk("fwd_no_match_rf", bus.eu0_src1, 32'hC);
  endtask

  task automatic test_stall_snoop();
    clear_inputs();
    bus.eu1_en_in = 1; bus.eu1_uop_in = 32'hBEEF; bus.eu1_rd_in = 8;
    bus.eu1_rj_in = 4; bus.eu1_rj_data = 32'h44;
    bus.eu1_rk_in = 7; bus.eu1_rk_data = 32'h1;
    @(negedge clk);
    chk("snoop_cap_src2", bus.eu1_src2, 32'h1);
    bus.stall_in = 1;
    bus.eu1_en_in = 0; bus.eu1_uop_in = 32'h0; bus.eu1_rk_in = 9; bus.eu1_rk_data = 32'h99;
    @(negedge clk);
    chk("snoop_stall1_src2", bus.eu1_src2, 32'h1);
    bus.wb_0_we = 1; bus.wb_0_rd = 7; bus.wb_0_data = 32'h55;
    @(negedge clk);
    chk("snoop_stall2_src2", bus.eu1_src2, 32'h55);
    chk("snoop_uop_held", bus.eu1_uop_out, 32'hBEEF);
    chk("snoop_rk_held", {27'b0, bus.eu1_rk_out}, 32'd7);
    chk("snoop_en_held", {31'b0, bus.eu1_en_out}, 32'h1);
    chk("snoop_src1_held", bus.eu1_src1, 32'h44);
    bus.wb_0_we = 0;
    @(negedge clk);
    chk("snoop_stall3_src2", bus.eu1_src2, 32'h55);
    bus.stall_in = 0; bus.eu1_en_in = 1;
    #1;
    chk("snoop_after_release", bus.eu1_src2, 32'h55);
    @(negedge clk);
    chk("snoop_next_capture", bus.eu1_src2, 32'h99);
    chk("snoop_next_rk", {27'b0, bus.eu1_rk_out}, 32'd9);
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    bus.eu0_en_in = 1; bus.eu1_en_in = 1;
    @(negedge clk);
    chk("flush_pre_en", {30'b0, bus.eu1_en_out, bus.eu0_en_out}, 32'h3);
    bus.stall_in = 1; bus.flush_in = 1;
    @(negedge clk);
    chk("flush_over_stall_en", {30'b0, bus.eu1_en_out, bus.eu0_en_out}, 32'h0);
    bus.stall_in = 0; bus.flush_in = 0;
    @(negedge clk);
    chk("flush_recapture", {30'b0, bus.eu1_en_out, bus.eu0_en_out}, 32'h3);
    bus.flush_in = 1;
    @(negedge clk);
    chk("flush_plain_en", {30'b0, bus.eu1_en_out, bus.eu0_en_out}, 32'h0);
  endtask

  task automatic test_r0_guard();
    clear_inputs();
    bus.eu0_en_in = 1; bus.eu0_rj_in = 0; bus.eu0_rj_data = 32'h77;
    bus.ex1_1_we = 1; bus.ex1_1_rd = 0; bus.ex1_1_data = 32'hDEAD;
    bus.eu1_en_in = 1; bus.eu1_rj_in = 0; bus.eu1_rj_data = 32'h88;
    @(negedge clk);
    chk("r0_lane0", bus.eu0_src1, 32'h0);
    chk("r0_lane1", bus.eu1_src1, 32'h0);
  endtask

  task automatic test_async_reset();
    clear_inputs();
    bus.eu0_en_in = 1; bus.eu0_rj_in = 6; bus.eu0_rj_data = 32'h66; bus.eu0_uop_in = 32'h5A;
    @(negedge clk);
    chk("arst_pre_src1", bus.eu0_src1, 32'h66);
    bus.stall_in = 1;
    #2;
    rstn = 0;
    #1;
    chk("arst_en0",  {31'b0, bus.eu0_en_out}, 32'h0);
    chk("arst_src1", bus.eu0_src1, 32'h0);
    chk("arst_uop",  bus.eu0_uop_out, 32'h0);
    @(negedge clk);
    rstn = 1;
    clear_inputs();
    bus.eu0_en_in = 1; bus.eu0_rj_in = 2; bus.eu0_rj_data = 32'h4;
    @(negedge clk);
    chk("arst_after_src1", bus.eu0_src1, 32'h4);
    chk("arst_after_en0",  {31'b0, bus.eu0_en_out}, 32'h1);
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    for (int i = 1; i <= 4; i++) begin
      bus.eu0_en_in = 1; bus.eu0_rj_in = 5'(i); bus.eu0_rj_data = 32'(i * 16 + 1);
      bus.eu1_en_in = i[0]; bus.eu1_rk_in = 5'(i + 10); bus.eu1_rk_data = 32'(i * 256);
      @(negedge clk);
      chk("b2b_src1", bus.eu0_src1, 32'(i * 16 + 1));
      chk("b2b_src2", bus.eu1_src2, 32'(i * 256));
      chk("b2b_en1",  {31'b0, bus.eu1_en_out}, {31'b0, i[0]});
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_fwd_priority();
    test_stall_snoop();
    test_flush_stall();
    test_r0_guard();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
